// File: rtl/flash_loader.sv
// Boot-time copy engine: streams a block of SPI NOR flash (READ 0x03) into the cache write port,
// packing each four received bytes into one little-endian 32-bit word.
module flash_loader #(
  parameter logic [23:0] FLASH_ADDRESS      = 24'h00_0000,
  parameter logic [31:0] CACHE_ADDRESS_BASE = 32'h0000_0000,
  parameter logic [31:0] TRANSFER_BYTES     = 32'h0001_0000,
  parameter int unsigned STARTUP_WAIT       = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        flash_clk,
  output logic        flash_mosi,
  output logic        flash_cs,
  input  logic        flash_miso,
  output logic [31:0] cache_address,
  output logic [31:0] cache_data_in,
  output logic [3:0]  cache_write_enable,
  input  logic        cache_busy
);

  typedef enum logic [2:0] {
    StIdle, StWait, StCmd, StAddr, StRead, StIssue, StWriteWait, StDone
  } state_e;

  localparam logic [31:0] CmdAddr    = {8'h03, FLASH_ADDRESS};
  localparam logic [31:0] TotalWords = TRANSFER_BYTES >> 2;

  state_e      state_q, state_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic [5:0]  phase_q, phase_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] words_q, words_d;
  logic        cs_q, cs_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  we_q, we_d;

  // The first received byte sits in the top of the shift register; swap so it lands in byte 0.
  logic [31:0] rx_word;
  assign rx_word = {shift_q[30:0], flash_miso};

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    phase_d    = phase_q;
    shift_d    = shift_q;
    words_d    = words_q;
    cs_d       = cs_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = done_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = we_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          busy_d     = 1'b1;
          done_d     = 1'b0;
          addr_d     = CACHE_ADDRESS_BASE;
          wait_cnt_d = '0;
          words_d    = '0;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (wait_cnt_q == 32'(STARTUP_WAIT)) begin
          cs_d    = 1'b0;
          phase_d = '0;
          state_d = StCmd;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end
      StCmd, StAddr: begin
        if (!phase_q[0]) begin
          sck_d  = 1'b0;
          mosi_d = CmdAddr[5'd31 - phase_q[5:1]];
        end else begin
          sck_d = 1'b1;
          if (phase_q == 6'd15) state_d = StAddr;
          if (phase_q == 6'd63) state_d = StRead;
        end
        phase_d = phase_q + 6'd1;
      end
      StRead: begin
        if (!phase_q[0]) begin
          sck_d  = 1'b0;
          mosi_d = 1'b0;
          // Phase 0 has no preceding high phase in this word, so nothing to sample yet.
          if (phase_q != 6'd0) shift_d = rx_word;
        end else begin
          sck_d = 1'b1;
          if (phase_q == 6'd63) state_d = StIssue;
        end
        phase_d = phase_q + 6'd1;
      end
      StIssue: begin
        sck_d   = 1'b0;
        shift_d = rx_word;
        data_d  = {rx_word[7:0], rx_word[15:8], rx_word[23:16], rx_word[31:24]};
        we_d    = 4'b1111;
        state_d = StWriteWait;
      end
      StWriteWait: begin
        if (!cache_busy) begin
          we_d    = 4'b0000;
          addr_d  = addr_q + 32'd4;
          words_d = words_q + 32'd1;
          phase_d = '0;
          state_d = (words_q + 32'd1 == TotalWords) ? StDone : StRead;
        end
      end
      StDone: begin
        cs_d   = 1'b1;
        sck_d  = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b1;
        if (start) begin
          busy_d     = 1'b1;
          done_d     = 1'b0;
          addr_d     = CACHE_ADDRESS_BASE;
          wait_cnt_d = '0;
          words_d    = '0;
          state_d    = StWait;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      phase_q    <= '0;
      shift_q    <= '0;
      words_q    <= '0;
      cs_q       <= 1'b1;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      addr_q     <= CACHE_ADDRESS_BASE;
      data_q     <= '0;
      we_q       <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      phase_q    <= phase_d;
      shift_q    <= shift_d;
      words_q    <= words_d;
      cs_q       <= cs_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign flash_clk          = sck_q;
  assign flash_mosi         = mosi_q;
  assign flash_cs           = cs_q;
  assign cache_address      = addr_q;
  assign cache_data_in      = data_q;
  assign cache_write_enable = we_q;

endmodule

// File: tb/tb_flash_loader.sv
// Directed bench for flash_loader: SPI flash model, back-pressuring cache model, and a table of
// two-word transfers with hand-computed timing and data.
module tb_flash_loader;

  localparam logic [31:0] Base = 32'h1000_0000;

  logic        clk, rst_n, start;
  logic        busy, done;
  logic        flash_clk, flash_mosi, flash_cs, flash_miso;
  logic [31:0] cache_address, cache_data_in;
  logic [3:0]  cache_write_enable;
  logic        cache_busy;

  flash_loader #(
    .FLASH_ADDRESS      (24'h12_3456),
    .CACHE_ADDRESS_BASE (Base),
    .TRANSFER_BYTES     (32'd8),
    .STARTUP_WAIT       (10)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .busy               (busy),
    .done               (done),
    .flash_clk          (flash_clk),
    .flash_mosi         (flash_mosi),
    .flash_cs           (flash_cs),
    .flash_miso         (flash_miso),
    .cache_address      (cache_address),
    .cache_data_in      (cache_data_in),
    .cache_write_enable (cache_write_enable),
    .cache_busy         (cache_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // SPI flash model (mode 0): bytes CD AB 34 12 78 56 EF BE from the start address.
  logic [7:0]  flash_mem [8];
  logic [31:0] cmd_sr;
  int          rise_cnt  = 0;
  int          sck_bad   = 0;
  int          mosi_bad  = 0;
  logic        miso_r;
  assign flash_miso = miso_r;

  always @(negedge flash_cs) begin
    rise_cnt = 0;
    cmd_sr   = '0;
  end

  always @(posedge flash_clk) begin
    if (flash_cs) sck_bad++;
    else begin
      if (rise_cnt < 32) cmd_sr = {cmd_sr[30:0], flash_mosi};
      else if (flash_mosi !== 1'b0) mosi_bad++;
      rise_cnt++;
    end
  end

  initial begin
    logic [7:0] b;
    int idx;
    miso_r = 1'b0;
    forever begin
      @(negedge flash_clk);
      #1;
      if (!flash_cs && rise_cnt >= 32) begin
        idx = rise_cnt - 32;
        if (idx < 64) begin
          b      = flash_mem[idx >> 3];
          miso_r = b[7 - (idx & 7)];
        end else miso_r = 1'b0;
      end
    end
  end

  // Cache model: optional 5-cycle busy per write, logs accepted writes.
  bit          bp_en    = 1'b0;
  bit          bp_armed = 1'b0;
  int          bp_left  = 0;
  int          wr_count = 0;
  int          we_bad   = 0;
  int          pause_bad = 0;
  logic [31:0] wr_addr [8];
  logic [31:0] wr_data [8];

  always @(negedge clk) begin
    if (cache_write_enable == 4'hf) begin
      if (!bp_armed) begin
        bp_armed = 1'b1;
        bp_left  = bp_en ? 5 : 0;
      end
      if (flash_clk !== 1'b0 || flash_cs !== 1'b0) pause_bad++;
    end else bp_armed = 1'b0;
    if (bp_left > 0) begin
      cache_busy = 1'b1;
      bp_left--;
    end else cache_busy = 1'b0;
    if (cache_busy && cache_write_enable != 4'hf) we_bad++;
    if (cache_write_enable == 4'hf && !cache_busy && wr_count < 8) begin
      wr_addr[wr_count] = cache_address;
      wr_data[wr_count] = cache_data_in;
      wr_count++;
    end
  end

  typedef struct {
    bit          bp;
    bit          mid_start;
    int          exp_done;
    logic [31:0] exp_w0;
    logic [31:0] exp_w1;
  } vec_t;

  vec_t vecs [4];

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs"},   32'(flash_cs), 32'd1);
    check({tag, "_sck"},  32'(flash_clk), 32'd0);
    check({tag, "_mosi"}, 32'(flash_mosi), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_we"},   32'(cache_write_enable), 32'd0);
    check({tag, "_addr"}, cache_address, Base);
    check({tag, "_data"}, cache_data_in, 32'd0);
  endtask

  task automatic run_xfer(input vec_t v);
    int cyc;
    int cs_fall;
    wr_count = 0;
    bp_en    = v.bp;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_done_clr", 32'(done), 32'd0);
    check("accept_addr", cache_address, Base);
    cyc     = 0;
    cs_fall = 0;
    while (cyc < 1000) begin
      @(posedge clk);
      cyc++;
      #1;
      start = (v.mid_start && cyc == 100);
      if (!flash_cs && cs_fall == 0) cs_fall = cyc;
      if (done) break;
    end
    start = 1'b0;
    check("done_cycle", 32'(cyc), 32'(v.exp_done));
    check("cs_fall_cycle", 32'(cs_fall), 32'd11);
    check("cs_high_at_done", 32'(flash_cs), 32'd1);
    check("busy_low_at_done", 32'(busy), 32'd0);
    check("cmd_addr", cmd_sr, 32'h0312_3456);
    check("sck_rises", 32'(rise_cnt), 32'd96);
    check("write_count", 32'(wr_count), 32'd2);
    check("w0_addr", wr_addr[0], Base);
    check("w0_data", wr_data[0], v.exp_w0);
    check("w1_addr", wr_addr[1], Base + 32'd4);
    check("w1_data", wr_data[1], v.exp_w1);
    check("final_addr", cache_address, Base + 32'd8);
    check("sck_while_cs_high", 32'(sck_bad), 32'd0);
    check("mosi_during_read", 32'(mosi_bad), 32'd0);
    check("pause_pins", 32'(pause_bad), 32'd0);
    check("we_held_while_busy", 32'(we_bad), 32'd0);
  endtask

  initial begin
    int k;
    flash_mem[0] = 8'hCD; flash_mem[1] = 8'hAB; flash_mem[2] = 8'h34; flash_mem[3] = 8'h12;
    flash_mem[4] = 8'h78; flash_mem[5] = 8'h56; flash_mem[6] = 8'hEF; flash_mem[7] = 8'hBE;
    // done edge: 10 + 1 + 64 + sum(64 + 1 + k) + 1; k = 1 (no busy) or 6 (5 busy cycles)
    vecs[0] = '{bp: 1'b0, mid_start: 1'b0, exp_done: 208, exp_w0: 32'h1234ABCD,
                exp_w1: 32'hBEEF5678};
    vecs[1] = '{bp: 1'b1, mid_start: 1'b0, exp_done: 218, exp_w0: 32'h1234ABCD,
                exp_w1: 32'hBEEF5678};
    vecs[2] = '{bp: 1'b0, mid_start: 1'b1, exp_done: 208, exp_w0: 32'h1234ABCD,
                exp_w1: 32'hBEEF5678};
    vecs[3] = '{bp: 1'b1, mid_start: 1'b1, exp_done: 218, exp_w0: 32'h1234ABCD,
                exp_w1: 32'hBEEF5678};

    start = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset_async");
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("idle_cs", 32'(flash_cs), 32'd1);
    check("idle_sck", 32'(flash_clk), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_sck_toggles", 32'(sck_bad), 32'd0);

    for (int i = 0; i < 4; i++) run_xfer(vecs[i]);

    // Reset during READ of the second word, then a full copy again.
    wr_count = 0;
    bp_en    = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    while (wr_count < 1 && k < 1000) begin
      @(posedge clk);
      k++;
    end
    check("midreset_first_write", 32'(wr_count), 32'd1);
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    repeat (5) @(posedge clk);
    #1;
    check("midreset_no_write", 32'(wr_count), 32'd1);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_reset_idle_busy", 32'(busy), 32'd0);
    check("post_reset_idle_cs", 32'(flash_cs), 32'd1);
    run_xfer(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
